vga_line_fetch: RTL and testbench

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

---
 rtl/vga_line_fetch.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_line_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// ---------------------------------------------------------------------------
// vga_line_fetch
//
// Purpose:
//   Ping-pong line buffer between a pixel memory and a vga_controller.
//   At the start of every horizontal blank (fetch_start) the two line banks
//   swap roles. The freshly written bank becomes the display bank. The other
//   bank is refilled from memory, one word per acknowledged request, with
//   the words for line fetch_line. Display reads have one cycle of latency.
//   Pixels that have not been fetched (yet) show a fill colour.
//
// Build option:
//   VGA_LINE_FETCH_UNDERRUN_COLOUR_EN - when defined, the fill colour is
//   magenta (FF,00,FF) so that starved lines stand out on screen. When it is
//   undefined, the fill colour is black.
//
// Ports:
//   vga_clk      in   1        pixel clock (single clock domain)
//   reset        in   1        synchronous, active-high
//   fetch_start  in   1        one-cycle pulse at the start of horizontal blank
//   fetch_line   in   10       line to prefetch, sampled with fetch_start
//   rd_en        in   1        active-video qualifier
//   rd_x         in   10       current pixel column
//   mem_req      out  1        read request to pixel memory
//   mem_addr     out  ADDR_W   word address, valid while mem_req is high
//   mem_ack      in   1        request accepted, mem_data valid this cycle
//   mem_data     in   24       RGB888 pixel, R in [23:16]
//   red/green/blue out 8 each  pixel to the vga_controller
//   busy         out  1        fetch FSM not idle
//   underrun     out  1        one-cycle pulse when a fetch is cut short
//
// FSM states:
//   state    | meaning
//   ST_IDLE  | no fetch in progress, mem_req low
//   ST_FETCH | requesting words base+fill until word H_ACTIVE-1 is acked
// ---------------------------------------------------------------------------
module vga_line_fetch #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [9:0]        fetch_line,
    input  logic              rd_en,
    input  logic [9:0]        rd_x,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [23:0]       mem_data,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              busy,
    output logic              underrun
);

    localparam int IDX_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int CNT_W = $clog2(H_ACTIVE + 1);

`ifdef VGA_LINE_FETCH_UNDERRUN_COLOUR_EN
    localparam logic [23:0] FILL_RGB = 24'hFF00FF;
`else
    localparam logic [23:0] FILL_RGB = 24'h000000;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_FETCH
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_FILL,
        SEL_PIX
    } sel_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_rd_bank;
    logic             w_wr_bank;
    logic [CNT_W-1:0] r_fill0;
    logic [CNT_W-1:0] r_fill1;
    logic [CNT_W-1:0] w_fill_wr;
    logic [CNT_W-1:0] w_fill_rd;

    // Kept at full product width; only cut down to ADDR_W when forming mem_addr.
    logic [31:0]      r_base;
    logic [31:0]      w_base_full;

    logic             w_line_ok;
    logic             w_ack;
    logic             w_last;
    logic             r_underrun;

    logic [23:0]      r_bank0 [H_ACTIVE];
    logic [23:0]      r_bank1 [H_ACTIVE];
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_in_line;
    logic             w_rd_hit;
    logic [23:0]      r_q;
    sel_t             r_sel;

    // ------------------------------------------------------------------
    // Bank bookkeeping
    // ------------------------------------------------------------------
    assign w_wr_bank   = ~r_rd_bank;
    assign w_fill_wr   = w_wr_bank ? r_fill1 : r_fill0;
    assign w_fill_rd   = r_rd_bank ? r_fill1 : r_fill0;

    assign w_base_full = 32'(fetch_line) * 32'(H_ACTIVE);
    assign w_line_ok   = 32'(fetch_line) < 32'(V_ACTIVE);

    // Acks are only honoured against an outstanding request, never in reset.
    assign w_ack       = (r_state == ST_FETCH) && mem_ack && !reset;
    assign w_last      = w_ack && (32'(w_fill_wr) == 32'(H_ACTIVE - 1));

    assign mem_addr    = ADDR_W'(r_base + 32'(w_fill_wr));
    assign underrun    = r_underrun;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fetch_start && w_line_ok) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                // A new line request always wins over completion of the old one.
                if (fetch_start) begin
                    w_state_nxt = w_line_ok ? ST_FETCH : ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bank swap, base address, fill counts, overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_rd_bank  <= 1'b0;
            r_base     <= '0;
            r_fill0    <= '0;
            r_fill1    <= '0;
            r_underrun <= 1'b0;
        end else begin
            // A fetch that finishes on the very cycle of the next start is
            // complete, so it is not reported as an overrun.
            r_underrun <= fetch_start && (r_state == ST_FETCH) && !w_last;

            if (fetch_start) begin
                r_rd_bank <= ~r_rd_bank;
                r_base    <= w_base_full;
            end

            // The bank being cleared (current display bank) and the bank being
            // incremented (current write bank) are always different, so a
            // coincident ack still lands in the old write bank before the swap.
            if (fetch_start && !r_rd_bank) begin
                r_fill0 <= '0;
            end else if (w_ack && !w_wr_bank) begin
                r_fill0 <= r_fill0 + 1'b1;
            end

            if (fetch_start && r_rd_bank) begin
                r_fill1 <= '0;
            end else if (w_ack && w_wr_bank) begin
                r_fill1 <= r_fill1 + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line RAMs: written on ack, no reset (fill counts gate visibility)
    // ------------------------------------------------------------------
    assign w_wr_idx = IDX_W'(w_fill_wr);

    always_ff @(posedge vga_clk) begin
        if (w_ack) begin
            if (w_wr_bank) begin
                r_bank1[w_wr_idx] <= mem_data;
            end else begin
                r_bank0[w_wr_idx] <= mem_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display read path: one cycle latency
    // ------------------------------------------------------------------
    assign w_rd_in_line = 32'(rd_x) < 32'(H_ACTIVE);
    assign w_rd_hit     = w_rd_in_line && (32'(rd_x) < 32'(w_fill_rd));
    // Clamp off-line columns so the RAM is never addressed out of range.
    assign w_rd_idx     = w_rd_in_line ? IDX_W'(rd_x) : '0;

    always_ff @(posedge vga_clk) begin
        r_q <= r_rd_bank ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_sel <= SEL_ZERO;
        end else if (!rd_en) begin
            r_sel <= SEL_ZERO;
        end else if (w_rd_hit) begin
            r_sel <= SEL_PIX;
        end else begin
            r_sel <= SEL_FILL;
        end
    end

    always_comb begin
        {red, green, blue} = 24'h000000;
        case (r_sel)
            SEL_FILL: {red, green, blue} = FILL_RGB;
            SEL_PIX:  {red, green, blue} = r_q;
            default:  {red, green, blue} = 24'h000000;
        endcase
    end

endmodule

// File: tb/tb_vga_line_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_line_fetch
//
// Directed bench for vga_line_fetch with default parameters (640x480).
// A memory model returns pix_of(address); expected display pixels are
// queued when a read is driven and popped when the output appears.
// VGA_LINE_FETCH_UNDERRUN_COLOUR_EN selects the expected fill colour.
// ---------------------------------------------------------------------------
module tb_vga_line_fetch;

    localparam int H = 640;

`ifdef VGA_LINE_FETCH_UNDERRUN_COLOUR_EN
    localparam logic [23:0] FILL = 24'hFF00FF;
`else
    localparam logic [23:0] FILL = 24'h000000;
`endif

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [9:0]  fetch_line;
    logic        rd_en;
    logic [9:0]  rd_x;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_ack;
    logic [23:0] mem_data;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        busy;
    logic        underrun;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] exp_q [$];

    always #5 vga_clk = ~vga_clk;

    function automatic logic [23:0] pix_of(input int a);
        return 24'(a * 131 + 7);
    endfunction

    assign mem_data = pix_of(int'(mem_addr));

    vga_line_fetch dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .fetch_line  (fetch_line),
        .rd_en       (rd_en),
        .rd_x        (rd_x),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .busy        (busy),
        .underrun    (underrun)
    );

    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one display read, then compare the pixel it produces a cycle later.
    task automatic rd(input logic en, input int x, input logic [23:0] e);
        logic [23:0] want;
        rd_en = en;
        rd_x  = 10'(x);
        exp_q.push_back(e);
        tick;
        want = exp_q.pop_front();
        chk($sformatf("pix x=%0d en=%0b", x, en), {8'h00, red, green, blue}, {8'h00, want});
    endtask

    task automatic fetch_pulse(input int line, input logic ack);
        fetch_start = 1'b1;
        fetch_line  = 10'(line);
        mem_ack     = ack;
        tick;
        fetch_start = 1'b0;
    endtask

    task automatic run_acks(input int base, input int n, input string tag);
        mem_ack = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk({tag, " req"}, 32'(mem_req), 32'd1);
            chk({tag, " addr"}, 32'(mem_addr), 32'(base + k));
            tick;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        fetch_start = 1'b0;
        fetch_line  = '0;
        rd_en       = 1'b0;
        rd_x        = '0;
        mem_ack     = 1'b0;
        tick; tick; tick;
        reset = 1'b0;

        // Reset state
        chk("rst rgb",      {8'h00, red, green, blue}, 32'd0);
        chk("rst mem_req",  32'(mem_req), 32'd0);
        chk("rst busy",     32'(busy), 32'd0);
        chk("rst underrun", 32'(underrun), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        rd(1'b1, 5, FILL);
        rd(1'b0, 5, 24'h0);

        // Full line 2 with ack held high: addresses 1280..1919
        fetch_pulse(2, 1'b1);
        chk("l2 busy", 32'(busy), 32'd1);
        run_acks(1280, H, "l2");
        chk("l2 done busy", 32'(busy), 32'd0);
        chk("l2 done req",  32'(mem_req), 32'd0);

        // Swap to display line 2; start line 3 with ack low
        fetch_pulse(3, 1'b0);
        chk("l3 start underrun", 32'(underrun), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("stall req",  32'(mem_req), 32'd1);
            chk("stall addr", 32'(mem_addr), 32'd1920);
            tick;
        end
        for (int k = 0; k < H; k++) begin
            rd(1'b1, k, pix_of(1280 + k));
        end
        rd(1'b1, 640, FILL);
        rd(1'b1, 1023, FILL);
        rd(1'b0, 7, 24'h0);
        chk("stall addr after", 32'(mem_addr), 32'd1920);

        // 100 acks then a premature fetch_start
        run_acks(1920, 100, "l3");
        fetch_pulse(4, 1'b0);
        chk("ovr underrun", 32'(underrun), 32'd1);
        chk("ovr busy",     32'(busy), 32'd1);
        chk("ovr addr",     32'(mem_addr), 32'd2560);
        tick;
        chk("ovr underrun 1cyc", 32'(underrun), 32'd0);
        rd(1'b1, 0,   pix_of(1920));
        rd(1'b1, 99,  pix_of(2019));
        rd(1'b1, 100, FILL);
        rd(1'b1, 639, FILL);

        // fetch_start coincident with the ack of word 10
        run_acks(2560, 10, "l4");
        chk("coinc addr pre", 32'(mem_addr), 32'd2570);
        fetch_pulse(5, 1'b1);
        mem_ack = 1'b0;
        chk("coinc underrun", 32'(underrun), 32'd1);
        chk("coinc addr",     32'(mem_addr), 32'd3200);
        rd(1'b1, 10, pix_of(2570));
        rd(1'b1, 11, FILL);
        run_acks(3200, H, "l5");
        chk("l5 done busy", 32'(busy), 32'd0);
        mem_ack = 1'b0;

        // Off-screen line: swap but no requests
        fetch_pulse(480, 1'b0);
        chk("l480 req",      32'(mem_req), 32'd0);
        chk("l480 busy",     32'(busy), 32'd0);
        chk("l480 underrun", 32'(underrun), 32'd0);
        rd(1'b1, 0,   pix_of(3200));
        rd(1'b1, 639, pix_of(3839));
        chk("l480 req later", 32'(mem_req), 32'd0);
        fetch_pulse(6, 1'b0);
        chk("l6 busy", 32'(busy), 32'd1);
        chk("l6 addr", 32'(mem_addr), 32'd3840);
        rd(1'b1, 0,   FILL);
        rd(1'b1, 300, FILL);
        rd(1'b1, 639, FILL);
        rd_en = 1'b0;

        // Reset at ack 50 of a fetch
        run_acks(3840, 50, "l6");
        reset   = 1'b1;
        mem_ack = 1'b1;
        tick;
        chk("mid rst req",      32'(mem_req), 32'd0);
        chk("mid rst busy",     32'(busy), 32'd0);
        chk("mid rst addr",     32'(mem_addr), 32'd0);
        chk("mid rst underrun", 32'(underrun), 32'd0);
        chk("mid rst rgb",      {8'h00, red, green, blue}, 32'd0);
        tick;
        chk("mid rst req hold", 32'(mem_req), 32'd0);
        chk("mid rst addr hold", 32'(mem_addr), 32'd0);
        reset   = 1'b0;
        mem_ack = 1'b0;
        tick;
        chk("post rst busy", 32'(busy), 32'd0);
        rd(1'b1, 0, FILL);
        rd(1'b0, 0, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
